// File: rtl/csr_regbank_avmm.sv
// Avalon-MM CSR register bank with per-register RW/RO/W1C/PULSE modes and a
// forwarded external window that uses a waitrequest handshake with a timeout.
module csr_regbank_avmm #(
    parameter int unsigned                  NUM_REGS     = 16,
    parameter int unsigned                  ADDR_W       = 12,
    parameter logic [NUM_REGS-1:0]          RO_MASK      = '0,
    parameter logic [NUM_REGS-1:0]          W1C_MASK     = '0,
    parameter logic [NUM_REGS-1:0]          PULSE_MASK   = '0,
    parameter logic [NUM_REGS*32-1:0]       RESET_VALUES = '0,
    parameter logic [ADDR_W-1:0]            EXT_BASE     = 'h800,
    parameter logic [ADDR_W-1:0]            EXT_SIZE     = 'h400,
    parameter int unsigned                  EXT_TIMEOUT  = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ADDR_W-1:0]      avs_address,
    input  logic                   avs_read,
    input  logic                   avs_write,
    input  logic [31:0]            avs_writedata,
    input  logic [3:0]             avs_byteenable,
    output logic [31:0]            avs_readdata,
    output logic                   avs_readdatavalid,
    output logic [1:0]             avs_response,
    output logic                   avs_waitrequest,
    output logic [NUM_REGS*32-1:0] reg_q,
    output logic [NUM_REGS-1:0]    reg_wr_pulse,
    input  logic [NUM_REGS*32-1:0] hw_status,
    input  logic [NUM_REGS*32-1:0] hw_set,
    output logic [ADDR_W-1:0]      ext_addr,
    output logic                   ext_rd,
    output logic                   ext_wr,
    output logic [31:0]            ext_wdata,
    output logic [3:0]             ext_be,
    input  logic [31:0]            ext_rdata,
    input  logic                   ext_ack,
    output logic [15:0]            ext_timeout_cnt
);

    localparam int unsigned CntW = (EXT_TIMEOUT > 2) ? $clog2(EXT_TIMEOUT) : 1;
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] RespDecErr = 2'b11;

    typedef enum logic {StIdle, StExtWait} state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [NUM_REGS*32-1:0]  regs_q, regs_d;
    logic [NUM_REGS-1:0]     wr_pulse_q, wr_pulse_d;
    logic                    rvalid_q, rvalid_d;
    logic [31:0]             rdata_q, rdata_d;
    logic [1:0]              resp_q, resp_d;
    logic [ADDR_W-1:0]       ext_addr_q, ext_addr_d;
    logic [31:0]             ext_wdata_q, ext_wdata_d;
    logic [3:0]              ext_be_q, ext_be_d;
    logic                    ext_rd_q, ext_rd_d;
    logic                    ext_wr_q, ext_wr_d;
    logic                    ext_is_rd_q, ext_is_rd_d;
    logic [15:0]             tmo_q, tmo_d;

    logic                    accept_wr, accept_rd;
    logic [31:0]             be_mask;
    logic [31:0]             word_idx;
    logic                    local_hit, ext_hit;
    logic [ADDR_W:0]         addr_ext;
    logic [ADDR_W-1:0]       ext_diff;
    logic [NUM_REGS-1:0]     wr_hit;
    logic [31:0]             local_rdata;

    assign accept_wr = (state_q == StIdle) && avs_write;
    assign accept_rd = (state_q == StIdle) && avs_read && !avs_write;
    assign be_mask   = {{8{avs_byteenable[3]}}, {8{avs_byteenable[2]}},
                        {8{avs_byteenable[1]}}, {8{avs_byteenable[0]}}};
    assign word_idx  = 32'(avs_address[ADDR_W-1:2]);
    assign local_hit = word_idx < NUM_REGS;
    assign addr_ext  = {1'b0, avs_address};
    assign ext_hit   = (addr_ext >= {1'b0, EXT_BASE}) &&
                       (addr_ext < ({1'b0, EXT_BASE} + {1'b0, EXT_SIZE}));
    assign ext_diff  = avs_address - EXT_BASE;

    // RO registers expose the live hardware status instead of stored state.
    always_comb begin
        reg_q       = regs_q;
        wr_hit      = '0;
        local_rdata = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (RO_MASK[i]) begin
                reg_q[i*32 +: 32] = hw_status[i*32 +: 32];
            end
            wr_hit[i] = accept_wr && local_hit && (word_idx == 32'(i));
            if (word_idx == 32'(i)) begin
                local_rdata = reg_q[i*32 +: 32];
            end
        end
    end

    always_comb begin
        regs_d     = regs_q;
        wr_pulse_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (RO_MASK[i]) begin
                regs_d[i*32 +: 32] = RESET_VALUES[i*32 +: 32];
            end else if (W1C_MASK[i]) begin
                if (wr_hit[i]) begin
                    regs_d[i*32 +: 32] = regs_q[i*32 +: 32] & ~(avs_writedata & be_mask);
                end
                // Set is applied last so it wins over a coincident clear.
                regs_d[i*32 +: 32] = regs_d[i*32 +: 32] | hw_set[i*32 +: 32];
            end else begin
                if (PULSE_MASK[i] && wr_pulse_q[i]) begin
                    regs_d[i*32 +: 32] = RESET_VALUES[i*32 +: 32];
                end
                if (wr_hit[i]) begin
                    regs_d[i*32 +: 32] = (regs_d[i*32 +: 32] & ~be_mask) |
                                         (avs_writedata & be_mask);
                end
            end
            wr_pulse_d[i] = wr_hit[i] && !RO_MASK[i];
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rvalid_d    = 1'b0;
        rdata_d     = rdata_q;
        resp_d      = resp_q;
        ext_addr_d  = ext_addr_q;
        ext_wdata_d = ext_wdata_q;
        ext_be_d    = ext_be_q;
        ext_rd_d    = 1'b0;
        ext_wr_d    = 1'b0;
        ext_is_rd_d = ext_is_rd_q;
        tmo_d       = tmo_q;
        unique case (state_q)
            StIdle: begin
                if (accept_wr || accept_rd) begin
                    if (local_hit) begin
                        if (accept_rd) begin
                            rvalid_d = 1'b1;
                            rdata_d  = local_rdata;
                            resp_d   = RespOkay;
                        end
                    end else if (ext_hit) begin
                        ext_addr_d  = {ext_diff[ADDR_W-1:2], 2'b00};
                        ext_wdata_d = avs_writedata;
                        ext_be_d    = avs_byteenable;
                        ext_is_rd_d = accept_rd;
                        ext_rd_d    = accept_rd;
                        ext_wr_d    = accept_wr;
                        cnt_d       = '0;
                        state_d     = StExtWait;
                    end else if (accept_rd) begin
                        rvalid_d = 1'b1;
                        rdata_d  = 32'hDEADBEEF;
                        resp_d   = RespDecErr;
                    end
                end
            end
            StExtWait: begin
                if (ext_ack) begin
                    state_d = StIdle;
                    if (ext_is_rd_q) begin
                        rvalid_d = 1'b1;
                        rdata_d  = ext_rdata;
                        resp_d   = RespOkay;
                    end
                end else if (cnt_q == CntW'(EXT_TIMEOUT - 1)) begin
                    state_d = StIdle;
                    if (ext_is_rd_q) begin
                        rvalid_d = 1'b1;
                        rdata_d  = 32'hDEADBEEF;
                        resp_d   = RespSlvErr;
                    end
                    if (tmo_q != 16'hFFFF) begin
                        tmo_d = tmo_q + 16'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            regs_q      <= RESET_VALUES;
            wr_pulse_q  <= '0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            resp_q      <= RespOkay;
            ext_addr_q  <= '0;
            ext_wdata_q <= '0;
            ext_be_q    <= '0;
            ext_rd_q    <= 1'b0;
            ext_wr_q    <= 1'b0;
            ext_is_rd_q <= 1'b0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            regs_q      <= regs_d;
            wr_pulse_q  <= wr_pulse_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
            ext_addr_q  <= ext_addr_d;
            ext_wdata_q <= ext_wdata_d;
            ext_be_q    <= ext_be_d;
            ext_rd_q    <= ext_rd_d;
            ext_wr_q    <= ext_wr_d;
            ext_is_rd_q <= ext_is_rd_d;
            tmo_q       <= tmo_d;
        end
    end

    assign avs_readdata      = rdata_q;
    assign avs_readdatavalid = rvalid_q;
    assign avs_response      = resp_q;
    assign avs_waitrequest   = (state_q == StExtWait);
    assign reg_wr_pulse      = wr_pulse_q;
    assign ext_addr          = ext_addr_q;
    assign ext_rd            = ext_rd_q;
    assign ext_wr            = ext_wr_q;
    assign ext_wdata         = ext_wdata_q;
    assign ext_be            = ext_be_q;
    assign ext_timeout_cnt   = tmo_q;

    logic unused_ok;
    assign unused_ok = ^{avs_address[1:0], hw_status, hw_set, regs_q};

endmodule

// File: tb/tb_csr_regbank_avmm.sv
// Scoreboard bench for csr_regbank_avmm: read responses are queued at issue time
// and checked by a monitor; side-band outputs are checked at the falling edge.
module tb_csr_regbank_avmm;

    localparam int unsigned NR = 16;
    localparam logic [NR*32-1:0] RV = {448'h0, 32'h33334444, 32'h11112222};

    logic               clk = 1'b0;
    logic               rst_n;
    logic [11:0]        avs_address;
    logic               avs_read, avs_write;
    logic [31:0]        avs_writedata;
    logic [3:0]         avs_byteenable;
    logic [31:0]        avs_readdata;
    logic               avs_readdatavalid;
    logic [1:0]         avs_response;
    logic               avs_waitrequest;
    logic [NR*32-1:0]   reg_q;
    logic [NR-1:0]      reg_wr_pulse;
    logic [NR*32-1:0]   hw_status, hw_set;
    logic [11:0]        ext_addr;
    logic               ext_rd, ext_wr;
    logic [31:0]        ext_wdata;
    logic [3:0]         ext_be;
    logic [31:0]        ext_rdata;
    logic               ext_ack;
    logic [15:0]        ext_timeout_cnt;

    csr_regbank_avmm #(
        .NUM_REGS(NR), .ADDR_W(12), .RO_MASK(16'h0020), .W1C_MASK(16'h0008),
        .PULSE_MASK(16'h0010), .RESET_VALUES(RV), .EXT_BASE(12'h800),
        .EXT_SIZE(12'h400), .EXT_TIMEOUT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .avs_address(avs_address), .avs_read(avs_read),
        .avs_write(avs_write), .avs_writedata(avs_writedata),
        .avs_byteenable(avs_byteenable), .avs_readdata(avs_readdata),
        .avs_readdatavalid(avs_readdatavalid), .avs_response(avs_response),
        .avs_waitrequest(avs_waitrequest), .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse),
        .hw_status(hw_status), .hw_set(hw_set), .ext_addr(ext_addr), .ext_rd(ext_rd),
        .ext_wr(ext_wr), .ext_wdata(ext_wdata), .ext_be(ext_be), .ext_rdata(ext_rdata),
        .ext_ack(ext_ack), .ext_timeout_cnt(ext_timeout_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rsp_t;

    rsp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_vcyc = -10;
    int   prev_vcyc = -20;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every readdatavalid must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && avs_readdatavalid) begin
            prev_vcyc = last_vcyc;
            last_vcyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rvalid: got data %h resp %b, expected no response",
                         avs_readdata, avs_response);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                if (avs_readdata !== e.data || avs_response !== e.resp) begin
                    errors++;
                    $display("FAIL read_rsp: got data %h resp %b, expected data %h resp %b",
                             avs_readdata, avs_response, e.data, e.resp);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    // Presents one command for one cycle; returns one step into the next cycle.
    task automatic issue(input bit wr, input bit rd, input logic [11:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        avs_write = wr;
        avs_read = rd;
        avs_address = a;
        avs_writedata = d;
        avs_byteenable = be;
        step();
        avs_write = 1'b0;
        avs_read = 1'b0;
    endtask

    task automatic expect_rd(input logic [31:0] d, input logic [1:0] r);
        rsp_t e;
        e.data = d;
        e.resp = r;
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        avs_address = '0;
        avs_read = 1'b0;
        avs_write = 1'b0;
        avs_writedata = '0;
        avs_byteenable = '0;
        hw_status = '0;
        hw_status[5*32 +: 32] = 32'hCAFEF00D;
        hw_set = '0;
        ext_rdata = 32'h12345678;
        ext_ack = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        at_neg();

        check("rst_reg0", reg_q[0 +: 32], 32'h11112222);
        check("rst_reg1", reg_q[32 +: 32], 32'h33334444);
        check("rst_reg2", reg_q[64 +: 32], 32'h0);
        check("rst_reg5_ro", reg_q[160 +: 32], 32'hCAFEF00D);
        check("rst_strobes", {reg_wr_pulse, ext_rd, ext_wr, avs_readdatavalid,
                              avs_waitrequest}, 32'h0);
        check("rst_readdata", avs_readdata, 32'h0);
        check("rst_resp_be", {avs_response, ext_be}, 32'h0);
        check("rst_ext", {ext_addr, ext_timeout_cnt}, 32'h0);
        check("rst_wdata", ext_wdata, 32'h0);
        step();

        // RW register with partial byte enables.
        issue(1, 0, 12'h008, 32'hAABBCCDD, 4'b0101);
        at_neg();
        check("rw_reg2", reg_q[64 +: 32], 32'h00BB00DD);
        check("rw_pulse", 32'(reg_wr_pulse), 32'h0004);
        step();
        at_neg();
        check("rw_pulse_end", 32'(reg_wr_pulse), 32'h0);
        step();
        expect_rd(32'h00BB00DD, 2'b00);
        issue(0, 1, 12'h008, 32'h0, 4'hF);

        // W1C: one-cycle hw_set, clear by write, then set racing a clear.
        hw_set[96 +: 32] = 32'h0F;
        step();
        hw_set[96 +: 32] = 32'h0;
        issue(1, 0, 12'h00C, 32'h05, 4'hF);
        expect_rd(32'h0A, 2'b00);
        issue(0, 1, 12'h00C, 32'h0, 4'hF);
        hw_set[96 +: 32] = 32'h01;
        issue(1, 0, 12'h00C, 32'h01, 4'hF);
        hw_set[96 +: 32] = 32'h0;
        at_neg();
        check("w1c_set_wins", reg_q[96 +: 32], 32'h0B);
        step();

        // PULSE register holds the written value for exactly one cycle.
        issue(1, 0, 12'h010, 32'h1, 4'hF);
        at_neg();
        check("pulse_hi", reg_q[128 +: 32], 32'h1);
        step();
        at_neg();
        check("pulse_lo", reg_q[128 +: 32], 32'h0);
        step();

        // RO register ignores writes and produces no write pulse.
        issue(1, 0, 12'h014, 32'hFFFFFFFF, 4'hF);
        at_neg();
        check("ro_val", reg_q[160 +: 32], 32'hCAFEF00D);
        check("ro_nopulse", 32'(reg_wr_pulse), 32'h0);
        step();
        expect_rd(32'hCAFEF00D, 2'b00);
        issue(0, 1, 12'h014, 32'h0, 4'hF);

        // Unmapped read, then back-to-back local reads.
        expect_rd(32'hDEADBEEF, 2'b11);
        issue(0, 1, 12'h7FC, 32'h0, 4'hF);
        expect_rd(32'h11112222, 2'b00);
        issue(0, 1, 12'h000, 32'h0, 4'hF);
        expect_rd(32'h33334444, 2'b00);
        issue(0, 1, 12'h004, 32'h0, 4'hF);
        at_neg();
        check("b2b_gap", 32'(last_vcyc - prev_vcyc), 32'd1);
        step();

        // External read acknowledged three cycles after ext_rd.
        expect_rd(32'h12345678, 2'b00);
        issue(0, 1, 12'h808, 32'h0, 4'hF);
        at_neg();
        check("ext_rd_pulse", {31'b0, ext_rd}, 32'h1);
        check("ext_addr", 32'(ext_addr), 32'h8);
        check("ext_wait_a1", {31'b0, avs_waitrequest}, 32'h1);
        step();
        at_neg();
        check("ext_rd_once", {31'b0, ext_rd}, 32'h0);
        check("ext_wait_a2", {31'b0, avs_waitrequest}, 32'h1);
        step();
        step();
        ext_ack = 1'b1;
        at_neg();
        check("ext_wait_ack", {31'b0, avs_waitrequest}, 32'h1);
        step();
        ext_ack = 1'b0;
        at_neg();
        check("ext_wait_done", {31'b0, avs_waitrequest}, 32'h0);
        step();

        // External write acknowledged in the first wait cycle.
        issue(1, 0, 12'h80C, 32'h000055AA, 4'b0011);
        ext_ack = 1'b1;
        at_neg();
        check("ext_wr_pulse", {31'b0, ext_wr}, 32'h1);
        check("ext_wr_fields", {ext_addr, ext_be, 16'h0}, {12'h00C, 4'b0011, 16'h0});
        check("ext_wdata", ext_wdata, 32'h000055AA);
        step();
        ext_ack = 1'b0;
        at_neg();
        check("ext_wr_done", {31'b0, avs_waitrequest}, 32'h0);
        step();

        // External read that times out after four wait cycles.
        expect_rd(32'hDEADBEEF, 2'b10);
        issue(0, 1, 12'h900, 32'h0, 4'hF);
        step();
        step();
        step();
        at_neg();
        check("tmo_wait_a4", {31'b0, avs_waitrequest}, 32'h1);
        step();
        at_neg();
        check("tmo_wait_a5", {31'b0, avs_waitrequest}, 32'h0);
        check("tmo_cnt", 32'(ext_timeout_cnt), 32'h1);
        step();

        // Reset in the middle of a wait aborts the access silently.
        issue(0, 1, 12'h810, 32'h0, 4'hF);
        step();
        rst_n = 1'b0;
        at_neg();
        check("rst_mid_wait", {30'b0, avs_waitrequest, avs_readdatavalid}, 32'h0);
        check("rst_mid_reg2", reg_q[64 +: 32], 32'h0);
        step();
        rst_n = 1'b1;
        repeat (6) step();
        at_neg();
        check("post_rst_idle", {31'b0, avs_waitrequest}, 32'h0);
        check("post_rst_tmo", 32'(ext_timeout_cnt), 32'h0);

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d responses outstanding, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
